// File: rtl/regfile_wb_queue.sv
// Write-back queue in front of the register file write port: buffers (addr, data)
// writes in FIFO order, drains one per cycle, and flags pending writes for hazard checks.
module regfile_wb_queue #(
  parameter int DATA_W = 64,
  parameter int ADDR_W = 5,
  parameter int DEPTH  = 4,
  parameter int CNT_W  = 3
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [ADDR_W-1:0] in_addr,
  input  logic [DATA_W-1:0] in_data,
  input  logic              wr_stall,
  output logic              wr_load,
  output logic [ADDR_W-1:0] wr_addr,
  output logic [DATA_W-1:0] wr_data,
  input  logic [ADDR_W-1:0] chk_addr,
  output logic              chk_pending,
  output logic [CNT_W-1:0]  count
);

  localparam int PTR_W = CNT_W - 1;

  logic [ADDR_W-1:0] addr_mem [DEPTH];
  logic [DATA_W-1:0] data_mem [DEPTH];
  logic [PTR_W-1:0]  head;
  logic [PTR_W-1:0]  tail;
  logic              push;
  logic              enq;
  logic              pop;

  // Handshake: a request transfers on a rising edge where in_valid && in_ready;
  // in_valid must not depend on in_ready, and in_ready never looks ahead at a pop.
  assign in_ready = (count < CNT_W'(DEPTH));
  assign push     = in_valid && in_ready;
  // Writes to register 0 complete the handshake but are dropped.
  assign enq      = push && (in_addr != '0);
  assign pop      = (count != '0) && !wr_stall;

  always_ff @(posedge clock) begin
    if (enq) begin
      addr_mem[tail] <= in_addr;
      data_mem[tail] <= in_data;
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      head    <= '0;
      tail    <= '0;
      count   <= '0;
      wr_load <= 1'b0;
      wr_addr <= '0;
      wr_data <= '0;
    end else begin
      if (enq) begin
        tail <= tail + 1'b1;
      end
      if (pop) begin
        head    <= head + 1'b1;
        wr_load <= 1'b1;
        wr_addr <= addr_mem[head];
        wr_data <= data_mem[head];
      end else begin
        wr_load <= 1'b0;
      end
      case ({enq, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  // Scan only the live entries starting at head; the presented write also counts.
  always_comb begin
    chk_pending = 1'b0;
    for (int i = 0; i < DEPTH; i++) begin
      if ((CNT_W'(i) < count) && (addr_mem[head + PTR_W'(i)] == chk_addr)) begin
        chk_pending = 1'b1;
      end
    end
    if (wr_load && (wr_addr == chk_addr)) begin
      chk_pending = 1'b1;
    end
    if (chk_addr == '0) begin
      chk_pending = 1'b0;
    end
  end

endmodule

// File: tb/tb_regfile_wb_queue.sv
// Bench for regfile_wb_queue: queue-based reference model compared every cycle,
// directed scenarios with literal expectations, then randomized traffic.
module tb_regfile_wb_queue;
  localparam int DATA_W = 64;
  localparam int ADDR_W = 5;
  localparam int DEPTH  = 4;
  localparam int CNT_W  = 3;

  logic              clock = 1'b0;
  logic              reset = 1'b1;
  logic              in_valid = 1'b0;
  logic              in_ready;
  logic [ADDR_W-1:0] in_addr = '0;
  logic [DATA_W-1:0] in_data = '0;
  logic              wr_stall = 1'b0;
  logic              wr_load;
  logic [ADDR_W-1:0] wr_addr;
  logic [DATA_W-1:0] wr_data;
  logic [ADDR_W-1:0] chk_addr = '0;
  logic              chk_pending;
  logic [CNT_W-1:0]  count;

  int checks = 0;
  int errors = 0;
  bit cmp_en = 1'b0;

  regfile_wb_queue #(
    .DATA_W(DATA_W), .ADDR_W(ADDR_W), .DEPTH(DEPTH), .CNT_W(CNT_W)
  ) dut (
    .clock(clock), .reset(reset), .in_valid(in_valid), .in_ready(in_ready),
    .in_addr(in_addr), .in_data(in_data), .wr_stall(wr_stall),
    .wr_load(wr_load), .wr_addr(wr_addr), .wr_data(wr_data),
    .chk_addr(chk_addr), .chk_pending(chk_pending), .count(count)
  );

  // Clock / reset
  always #5 clock = ~clock;

  task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%h exp=%h at %0t", name, got, exp, $time);
    end
  endtask

  // Reference model: a plain FIFO of {addr, data} plus the presented write
  logic [ADDR_W+DATA_W-1:0] exp_q[$];
  logic              m_load = 1'b0;
  logic [ADDR_W-1:0] m_addr = '0;
  logic [DATA_W-1:0] m_data = '0;
  logic              m_push;
  logic              m_pop;

  always @(posedge clock or posedge reset) begin
    if (reset) begin
      exp_q.delete();
      m_load = 1'b0;
      m_addr = '0;
      m_data = '0;
    end else begin
      m_push = in_valid && (exp_q.size() < DEPTH);
      m_pop  = (exp_q.size() > 0) && !wr_stall;
      if (m_pop) begin
        {m_addr, m_data} = exp_q.pop_front();
        m_load = 1'b1;
      end else begin
        m_load = 1'b0;
      end
      if (m_push && in_addr != '0) exp_q.push_back({in_addr, in_data});
    end
  end

  function automatic logic model_pending(input logic [ADDR_W-1:0] a);
    logic hit = 1'b0;
    if (a == '0) return 1'b0;
    foreach (exp_q[i]) if (exp_q[i][ADDR_W+DATA_W-1:DATA_W] == a) hit = 1'b1;
    if (m_load && m_addr == a) hit = 1'b1;
    return hit;
  endfunction

  // Scoreboard compare, once per cycle away from the active edge
  always @(negedge clock) begin
    if (cmp_en) begin
      check("cyc_wr_load", 64'(wr_load), 64'(m_load));
      check("cyc_wr_addr", 64'(wr_addr), 64'(m_addr));
      check("cyc_wr_data", wr_data, m_data);
      check("cyc_count", 64'(count), 64'(exp_q.size()));
      check("cyc_in_ready", 64'(in_ready), 64'(exp_q.size() < DEPTH));
      check("cyc_chk_pending", 64'(chk_pending), 64'(model_pending(chk_addr)));
    end
  end

  // Driver tasks: inputs change 1ns after the active edge
  task automatic step();
    @(posedge clock);
    #1;
  endtask

  task automatic drive(input logic v, input logic [ADDR_W-1:0] a, input logic [DATA_W-1:0] d);
    in_valid = v;
    in_addr  = a;
    in_data  = d;
  endtask

  initial begin
    repeat (2) step();
    reset = 1'b0;
    cmp_en = 1'b1;
    #1;

    // Reset state
    chk_addr = 5'd5;
    #1;
    check("rst_wr_load", 64'(wr_load), 64'd0);
    check("rst_wr_addr", 64'(wr_addr), 64'd0);
    check("rst_wr_data", wr_data, 64'd0);
    check("rst_count", 64'(count), 64'd0);
    check("rst_in_ready", 64'(in_ready), 64'd1);
    check("rst_chk_pending", 64'(chk_pending), 64'd0);

    // Single write latency
    step();
    drive(1'b1, 5'd3, 64'h1122334455667788);
    step();
    drive(1'b0, 5'd0, 64'd0);
    check("single_count_n", 64'(count), 64'd1);
    step();
    check("single_wr_load", 64'(wr_load), 64'd1);
    check("single_wr_addr", 64'(wr_addr), 64'd3);
    check("single_wr_data", wr_data, 64'h1122334455667788);
    check("single_count_n1", 64'(count), 64'd0);
    step();
    check("single_load_off", 64'(wr_load), 64'd0);

    // Fill under stall, then drain
    wr_stall = 1'b1;
    for (int i = 1; i <= 4; i++) begin
      drive(1'b1, 5'(i), 64'(i * 16));
      step();
    end
    check("full_count", 64'(count), 64'd4);
    check("full_in_ready", 64'(in_ready), 64'd0);
    drive(1'b1, 5'd9, 64'h99);
    step();
    drive(1'b0, 5'd0, 64'd0);
    check("full_reject", 64'(count), 64'd4);
    chk_addr = 5'd2;
    #1;
    check("full_chk2", 64'(chk_pending), 64'd1);
    chk_addr = 5'd7;
    #1;
    check("full_chk7", 64'(chk_pending), 64'd0);
    chk_addr = 5'd9;
    #1;
    check("full_chk9", 64'(chk_pending), 64'd0);
    wr_stall = 1'b0;
    for (int i = 1; i <= 4; i++) begin
      step();
      check("drain_load", 64'(wr_load), 64'd1);
      check("drain_addr", 64'(wr_addr), 64'(i));
      check("drain_data", wr_data, 64'(i * 16));
      check("drain_ready", 64'(in_ready), 64'd1);
    end
    step();
    check("drain_done", 64'(wr_load), 64'd0);

    // Continuous streaming, pointers wrap
    for (int i = 0; i < 10; i++) begin
      drive(1'b1, 5'd5, 64'(i));
      step();
      check("stream_count_le1", 64'(count <= 1), 64'd1);
      if (i > 0) begin
        check("stream_load", 64'(wr_load), 64'd1);
        check("stream_data", wr_data, 64'(i - 1));
      end
    end
    drive(1'b0, 5'd0, 64'd0);
    step();
    check("stream_last", wr_data, 64'd9);
    step();

    // Write to register 0 is swallowed
    drive(1'b1, 5'd0, 64'hFFFF);
    step();
    drive(1'b0, 5'd0, 64'd0);
    check("r0_count", 64'(count), 64'd0);
    for (int i = 0; i < 3; i++) begin
      step();
      check("r0_no_load", 64'(wr_load), 64'd0);
    end

    // Asynchronous reset mid-stream
    wr_stall = 1'b1;
    for (int i = 0; i < 3; i++) begin
      drive(1'b1, 5'(10 + i), 64'(100 + i));
      step();
    end
    drive(1'b0, 5'd0, 64'd0);
    chk_addr = 5'd11;
    #1;
    check("pre_rst_count", 64'(count), 64'd3);
    check("pre_rst_chk", 64'(chk_pending), 64'd1);
    #1 reset = 1'b1;
    #1;
    check("arst_count", 64'(count), 64'd0);
    check("arst_wr_addr", 64'(wr_addr), 64'd0);
    check("arst_wr_data", wr_data, 64'd0);
    check("arst_chk", 64'(chk_pending), 64'd0);
    step();
    reset = 1'b0;
    wr_stall = 1'b0;
    for (int i = 0; i < 4; i++) begin
      step();
      check("post_rst_no_load", 64'(wr_load), 64'd0);
    end

    // Randomized traffic against the model
    for (int i = 0; i < 2000; i++) begin
      drive(1'($urandom_range(0, 1)), 5'($urandom_range(0, 7)), {$urandom, $urandom});
      wr_stall = ($urandom_range(0, 9) < 3);
      chk_addr = 5'($urandom_range(0, 7));
      step();
    end
    drive(1'b0, 5'd0, 64'd0);
    wr_stall = 1'b0;
    repeat (DEPTH + 2) step();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/regfile_wb_queue.md
Name: regfile_wb_queue

Overview:
- Write-back buffer that sits directly upstream of the register file write port.
- Accepts write requests (address, data) from the execute/write-back stage through a valid/ready handshake and queues them in order.
- Drains one request per cycle into the register file by driving the per-register load enable, address and data.
- Reports whether any queued or in-flight write targets a given register, for hazard checking by the read side.

Parameters:
DATA_W, 64, width of register data
ADDR_W, 5, register address width (32 registers)
DEPTH, 4, queue entries; power of two, at least 2
CNT_W, 3, count width; must equal log2(DEPTH)+1

Ports:
clock  input  1  rising-edge clock
reset  input  1  asynchronous, active-high reset
in_valid  input  1  write request present
in_ready  output  1  queue can accept; combinational, equals (count < DEPTH)
in_addr  input  ADDR_W  destination register
in_data  input  DATA_W  write value
wr_stall  input  1  write port reserved by another source this cycle; suppresses pop
wr_load  output  1  registered load strobe to the register file
wr_addr  output  ADDR_W  registered destination, decoded downstream into per-register load
wr_data  output  DATA_W  registered write data
chk_addr  input  ADDR_W  register address to check for pending writes
chk_pending  output  1  combinational: a write to chk_addr is queued or presented on wr_*
count  output  CNT_W  current number of queued entries (excludes the presented entry)

Behaviour:
- Reset (asynchronous, active-high) clears the following immediately:
  - count = 0; head and tail pointers = 0.
  - wr_load = 0, wr_addr = 0, wr_data = 0.
  - All queued entries are discarded, including on reset mid-operation. The storage array itself need not be cleared.
- Push: occurs at a rising edge when in_valid && in_ready.
  - If in_addr == 0, the handshake completes but nothing is enqueued (register 0 is hardwired zero).
  - Otherwise the {in_addr, in_data} entry is written at the tail; tail increments modulo DEPTH.
- Pop: occurs at a rising edge when count > 0 && !wr_stall.
  - The head entry is copied into wr_addr/wr_data and wr_load is set to 1; head increments modulo DEPTH.
- When no pop occurs, wr_load is set to 0 at that edge; wr_addr/wr_data hold their previous values.
- wr_load is high for exactly one cycle per popped entry. Back-to-back pops give continuous wr_load high with new addr/data each cycle.
- Latency: a request accepted at edge N is popped at edge N+1 at the earliest. wr_load is high between edges N+1 and N+2, and the register file captures the value at edge N+2.
- Simultaneous push and pop:
  - Both take effect at the same edge; count is unchanged.
  - If count == 0, a same-cycle push is not popped until the next edge (no bypass).
- Full (count == DEPTH): in_ready = 0 even if a pop occurs that cycle (no pass-through on full).
- Empty (count == 0): no pop; wr_load goes 0 at the next edge.
- Ordering: strict FIFO. Multiple queued writes to the same address are all delivered in order, so the last one wins in the register file.
- Pointer wrap-around: head and tail wrap from DEPTH-1 to 0. Count distinguishes full from empty.
- chk_pending is 1 when either of the following holds (chk_addr == 0 always gives 0):
  - any of the count valid entries, from head onward, has addr == chk_addr; or
  - wr_load == 1 and wr_addr == chk_addr.
- chk_pending is purely combinational from state and chk_addr. It does not include the entry being pushed in the current cycle.
- wr_stall does not affect push acceptance.

Test Plan:
- Reset then idle → wr_load=0, wr_addr=0, wr_data=0, count=0, in_ready=1, chk_pending=0 for any chk_addr.
- Push addr 3 / data 0x1122334455667788 at edge N, wr_stall=0 → count=1 after N; wr_load=1, wr_addr=3, wr_data=0x1122334455667788 between edges N+1 and N+2; count=0 after N+1; wr_load=0 after N+2.
- wr_stall=1, push addrs 1, 2, 3, 4 with data 0x10..0x40 → count reaches 4, in_ready=0, a 5th in_valid is not accepted. With chk_addr=2, chk_pending=1; with chk_addr=7, chk_pending=0. Release stall → four consecutive wr_load pulses in order 1, 2, 3, 4, and in_ready=1 from the cycle after the first pop.
- Continuous push every cycle with wr_stall=0, 10 entries (addr 5, data 0..9) → count stays ≤1, pointers wrap twice, all ten writes appear on wr_* in order with no gaps after the first.
- Push addr 0 / data 0xFFFF → handshake accepted, count stays 0, wr_load never asserts.
- Three entries queued under stall, assert reset for one cycle mid-stream → outputs and count go to 0 immediately (asynchronous), chk_pending=0, and no queued writes appear after reset release.
